// File: rtl/hdr_arb_pkg.sv
// Shared types for the header+payload frame mux arbiter: FSM state encoding and select-width helper.
// Pure declarations; no latency or flow control of its own.
package hdr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // A one-source mux still needs a 1-bit select port.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Picks one requester: rotating priority starting after ptr, or fixed lowest-index-wins.
// Purely combinational, zero latency; no flow control, it only reports the winner.
module rr_priority_encoder #(
  parameter int S_COUNT     = 4,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int IDX_W       = 2
) (
  input  logic [S_COUNT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index,
  output logic [S_COUNT-1:0] onehot
);

  int cand;

  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    cand   = 0;
    for (int i = 0; i < S_COUNT; i++) begin
      cand = ROUND_ROBIN ? (int'(ptr) + 1 + i) % S_COUNT : i;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
    if (valid) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/hdr_frame_arbiter.sv
// Sequences the frame mux: grant one source, hold until header accepted and last payload beat leaves; outputs registered, 1 cycle request->enable.
// Never stalls anything itself; output backpressure just extends the grant. HDR_ARB_FRAME_CNT_EN adds per-source completed-frame counters.
module hdr_frame_arbiter
  import hdr_arb_pkg::*;
#(
  parameter  int S_COUNT         = 4,
  parameter  bit ARB_ROUND_ROBIN = 1'b1,
  parameter  int CNT_WIDTH       = 32,
  localparam int CL_S_COUNT      = clog2_min1(S_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [S_COUNT-1:0]           s_hdr_valid,
  input  logic [S_COUNT-1:0]           s_hdr_ready,
  input  logic                         m_payload_axis_tvalid,
  input  logic                         m_payload_axis_tready,
  input  logic                         m_payload_axis_tlast,
  output logic                         enable,
  output logic [CL_S_COUNT-1:0]        select,
  output logic [S_COUNT-1:0]           grant,
  output logic                         busy,
  output logic [S_COUNT*CNT_WIDTH-1:0] frame_count
);

  state_t                state, state_nxt;
  logic                  enable_nxt, busy_nxt;
  logic [CL_S_COUNT-1:0] select_nxt, last_ptr, ptr_nxt;
  logic [S_COUNT-1:0]    grant_nxt;
  logic                  arb_valid;
  logic [CL_S_COUNT-1:0] arb_index;
  logic [S_COUNT-1:0]    arb_onehot;
  logic                  hdr_accept, frame_done;

  rr_priority_encoder #(
    .S_COUNT     (S_COUNT),
    .ROUND_ROBIN (ARB_ROUND_ROBIN),
    .IDX_W       (CL_S_COUNT)
  ) u_enc (
    .req    (s_hdr_valid),
    .ptr    (last_ptr),
    .valid  (arb_valid),
    .index  (arb_index),
    .onehot (arb_onehot)
  );

  assign hdr_accept = s_hdr_valid[select] && s_hdr_ready[select];
  assign frame_done = (state == PAYLOAD) && m_payload_axis_tvalid
                      && m_payload_axis_tready && m_payload_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      enable   <= 1'b0;
      select   <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      last_ptr <= CL_S_COUNT'(S_COUNT - 1);
    end else begin
      state    <= state_nxt;
      enable   <= enable_nxt;
      select   <= select_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      last_ptr <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    enable_nxt = enable;
    select_nxt = select;
    grant_nxt  = grant;
    busy_nxt   = busy;
    ptr_nxt    = last_ptr;
    case (state)
      IDLE: begin
        enable_nxt = 1'b0;
        select_nxt = '0;
        grant_nxt  = '0;
        busy_nxt   = 1'b0;
        if (arb_valid) begin
          state_nxt  = GRANT;
          enable_nxt = 1'b1;
          select_nxt = arb_index;
          grant_nxt  = arb_onehot;
          busy_nxt   = 1'b1;
        end
      end
      GRANT: begin
        // Pointer commits only on acceptance so a withdrawn request leaves the rotation untouched.
        // A tlast seen here belongs to an earlier frame and is deliberately ignored.
        if (hdr_accept) begin
          state_nxt  = PAYLOAD;
          enable_nxt = 1'b0;
          ptr_nxt    = select;
        end else if (!s_hdr_valid[select]) begin
          state_nxt  = IDLE;
          enable_nxt = 1'b0;
          select_nxt = '0;
          grant_nxt  = '0;
          busy_nxt   = 1'b0;
        end
      end
      PAYLOAD: begin
        enable_nxt = 1'b0;
        if (frame_done) begin
          state_nxt  = IDLE;
          select_nxt = '0;
          grant_nxt  = '0;
          busy_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        enable_nxt = 1'b0;
        select_nxt = '0;
        grant_nxt  = '0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

`ifdef HDR_ARB_FRAME_CNT_EN
  logic [CNT_WIDTH-1:0] cnt [S_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < S_COUNT; i++) cnt[i] <= '0;
    end else if (frame_done) begin
      cnt[select] <= cnt[select] + 1'b1;
    end
  end

  for (genvar g = 0; g < S_COUNT; g++) begin : g_cnt
    assign frame_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end
`else
  assign frame_count = '0;
`endif

endmodule
